// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity modes and bit-period helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic int clks_per_bit(input int sys_clk, input int baud);
        return sys_clk / baud;
    endfunction

endpackage

// File: rtl/uart_tx_bitcnt.sv
// Bit-period counter: counts enabled cycles and flags the last cycle of a bit.
// clear has priority and restarts the period from zero.
module uart_tx_bitcnt #(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT * 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = en && (count_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1/8E1/8O1 with one or two stop bits, valid/ready input.
// The serial line is registered; the next line level is derived from the next state.
module uart_tx
    import uart_pkg::*;
#(
    parameter logic [1:0] PARITY_MODE = 2'b00,
    parameter bit         STOP_MODE   = 1'b0,
    parameter int         SYSTEM_CLK  = 10000000,
    parameter int         BAUD_RATE   = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_i_data,
    input  logic       tx_i_valid,
    output logic       tx_o_ready,
    output logic       tx_o_serial,
    output logic       tx_o_busy,
    output logic       tx_o_done
);

    localparam int         CLKS_PER_BIT = clks_per_bit(SYSTEM_CLK, BAUD_RATE);
    localparam bit         PAR_EN       = (PARITY_MODE == PAR_EVEN) || (PARITY_MODE == PAR_ODD);
    localparam bit         PAR_INV      = (PARITY_MODE == PAR_ODD);
    localparam logic [2:0] LAST_STOP    = {2'b00, STOP_MODE};

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx: SYSTEM_CLK/BAUD_RATE must be at least 2");
    end

    uart_state_e state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  idx_q, idx_d;
    logic        serial_q, serial_d;
    logic        tick;
    logic        cnt_clear;

    // Period restarts at every bit boundary and is held at zero while idle.
    assign cnt_clear = tick || (state_q == IDLE);

    uart_tx_bitcnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bitcnt (
        .clk  (clk),
        .reset(reset),
        .clear(cnt_clear),
        .en   (state_q != IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            serial_q <= serial_d;
        end
        data_q <= data_d;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (tx_i_valid) begin
                    state_d = START;
                    data_d  = tx_i_data;
                    idx_d   = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == 3'd7) begin
                        state_d = PAR_EN ? PARITY : STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    idx_d   = '0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (idx_q == LAST_STOP) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        tx_o_ready = (state_q == IDLE);
        tx_o_busy  = (state_q != IDLE);
        tx_o_done  = (state_q == STOP) && tick && (idx_q == LAST_STOP);
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = data_d[idx_d];
            PARITY:  serial_d = (^data_d) ^ PAR_INV;
            default: serial_d = 1'b1;
        endcase
    end

    assign tx_o_serial = serial_q;

endmodule
